// File: rtl/hdr_pkg.sv
// Shared header-collector types: bus widths, write FSM states and the slot record.
// The downstream egress buffer reuses the slot record as-is.
package hdr_pkg;

    localparam int unsigned BYTE_BUS    = 8;
    localparam int unsigned HDR_MAX_LEN = 64;
    localparam int unsigned NUM_PORTS   = 4;
    localparam int unsigned LEN_W       = $clog2(HDR_MAX_LEN + 1);
    localparam int unsigned IDX_W       = $clog2(HDR_MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } wr_state_e;

    typedef logic [0:HDR_MAX_LEN-1][BYTE_BUS-1:0] hdr_bytes_t;

    typedef struct packed {
        hdr_bytes_t           hdr;
        logic [LEN_W-1:0]     hdr_len;
        logic [NUM_PORTS-1:0] out_port;
    } hdr_slot_t;

endpackage

// File: rtl/hdr_collector_if.sv
// Stream ingress and processor-side empty/read handshake of the header collector.
interface hdr_collector_if;
    import hdr_pkg::*;

    logic                 in_valid_i;
    logic [BYTE_BUS-1:0]  in_data_i;
    logic                 in_last_i;
    logic [NUM_PORTS-1:0] in_src_port_i;
    logic                 in_ready_o;
    logic                 empty_o;
    logic                 rd_i;
    hdr_bytes_t           pkt_hdr_o;
    logic [LEN_W-1:0]     hdr_len_o;
    logic [NUM_PORTS-1:0] out_port_o;
    logic [31:0]          pkt_cnt_o;

    modport master (
        output in_valid_i, in_data_i, in_last_i, in_src_port_i, rd_i,
        input  in_ready_o, empty_o, pkt_hdr_o, hdr_len_o, out_port_o, pkt_cnt_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, in_src_port_i, rd_i,
        output in_ready_o, empty_o, pkt_hdr_o, hdr_len_o, out_port_o, pkt_cnt_o
    );

endinterface

// File: rtl/hdr_slot_ring.sv
// Ring of completed header slots with read/write pointers and occupancy count.
// The head slot is presented straight from registers.
module hdr_slot_ring
    import hdr_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_en,
    input  hdr_slot_t                    i_wr_slot,
    input  logic                         i_rd,
    output hdr_slot_t                    o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    hdr_slot_t        r_slots [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    // A read against an empty ring is ignored.
    assign w_pop = i_rd && (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slots  <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_slots[r_wr_ptr] <= i_wr_slot;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_slots[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/hdr_collector.sv
// Captures the first HDR_MAX_LEN bytes of each frame plus a flood-except-source
// egress mask, and queues completed headers for the packet processor.
module hdr_collector
    import hdr_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    hdr_collector_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wr_state_e        r_state;
    wr_state_e        w_state;
    hdr_slot_t        r_slot;
    hdr_slot_t        w_slot;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] w_idx;
    logic [31:0]      r_pkt_cnt;
    logic             w_commit;
    logic             w_accept;
    logic             w_ready;
    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    hdr_slot_t        w_head;

    // Stall only before a frame starts; a started frame already owns a free slot.
    assign w_ready  = !((r_state == S_IDLE) && (w_count == CNT_W'(DEPTH)));
    assign w_accept = bus.in_valid_i && w_ready;

    always_comb begin
        w_state  = r_state;
        w_slot   = r_slot;
        w_idx    = r_idx;
        w_commit = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    w_slot          = '0;
                    w_slot.hdr[0]   = bus.in_data_i;
                    w_slot.out_port = ~bus.in_src_port_i;
                    w_slot.hdr_len  = LEN_W'(1);
                    w_idx           = LEN_W'(1);
                    if (bus.in_last_i) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    w_slot.hdr[r_idx[IDX_W-1:0]] = bus.in_data_i;
                    w_idx                        = r_idx + LEN_W'(1);
                    w_slot.hdr_len               = w_idx;
                    if (bus.in_last_i) begin
                        w_commit = 1'b1;
                        w_state  = S_IDLE;
                    end else if (w_idx == LEN_W'(HDR_MAX_LEN)) begin
                        w_state = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.in_last_i) begin
                        w_commit = 1'b1;
                        w_state  = S_IDLE;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_slot    <= '0;
            r_idx     <= '0;
            r_pkt_cnt <= '0;
        end else begin
            r_state <= w_state;
            r_slot  <= w_slot;
            r_idx   <= w_idx;
            if (w_commit) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    // Commit writes the merged slot (including the final byte) in the same cycle.
    hdr_slot_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_commit),
        .i_wr_slot (w_slot),
        .i_rd      (bus.rd_i),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_empty   (w_empty)
    );

    assign bus.in_ready_o = w_ready;
    assign bus.empty_o    = w_empty;
    assign bus.pkt_hdr_o  = w_head.hdr;
    assign bus.hdr_len_o  = w_head.hdr_len;
    assign bus.out_port_o = w_head.out_port;
    assign bus.pkt_cnt_o  = r_pkt_cnt;

endmodule

// File: tb/tb_hdr_collector.sv
// Bench for hdr_collector: directed scenarios plus random frames, checked every
// cycle against a queue-based frame model.
module tb_hdr_collector;
    import hdr_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hdr_collector_if bus ();

    hdr_collector #(
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: completed headers waiting, bytes of the frame in flight, commit count.
    hdr_slot_t            m_q[$];
    logic [BYTE_BUS-1:0]  m_cur[$];
    logic [NUM_PORTS-1:0] m_src;
    bit                   m_busy;
    logic [31:0]          m_cnt;

    function automatic bit m_ready();
        return m_busy || (m_q.size() < int'(DEPTH));
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cur.delete();
        m_busy = 1'b0;
        m_cnt  = '0;
        m_src  = '0;
    endtask

    task automatic model_edge(input bit v, input logic [BYTE_BUS-1:0] d, input bit l,
                              input logic [NUM_PORTS-1:0] s, input bit r);
        bit        acc;
        hdr_slot_t h;
        int        n;
        acc = v && m_ready();
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (acc) begin
            if (!m_busy) begin
                m_cur.delete();
                m_src  = s;
                m_busy = 1'b1;
            end
            m_cur.push_back(d);
            if (l) begin
                h = '0;
                n = (m_cur.size() < int'(HDR_MAX_LEN)) ? m_cur.size() : int'(HDR_MAX_LEN);
                for (int i = 0; i < n; i++) h.hdr[i] = m_cur[i];
                h.hdr_len  = LEN_W'(n);
                h.out_port = ~m_src;
                m_q.push_back(h);
                m_cnt  = m_cnt + 32'd1;
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic pin(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all();
        hdr_slot_t h;
        pin("empty_o", 512'(bus.empty_o), 512'(m_q.size() == 0));
        pin("in_ready_o", 512'(bus.in_ready_o), 512'(m_ready()));
        pin("pkt_cnt_o", 512'(bus.pkt_cnt_o), 512'(m_cnt));
        if (m_q.size() > 0) begin
            h = m_q[0];
            pin("hdr_len_o", 512'(bus.hdr_len_o), 512'(h.hdr_len));
            pin("out_port_o", 512'(bus.out_port_o), 512'(h.out_port));
            n_cmp++;
            if (bus.pkt_hdr_o !== h.hdr) begin
                n_bad++;
                for (int i = 0; i < int'(HDR_MAX_LEN); i++) begin
                    if (bus.pkt_hdr_o[i] !== h.hdr[i]) begin
                        $display("FAIL pkt_hdr_o[%0d]: got %0h expected %0h",
                                 i, bus.pkt_hdr_o[i], h.hdr[i]);
                        break;
                    end
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at the next fall.
    task automatic cyc(input bit v, input logic [BYTE_BUS-1:0] d, input bit l,
                       input logic [NUM_PORTS-1:0] s, input bit r);
        bus.in_valid_i    = v;
        bus.in_data_i     = d;
        bus.in_last_i     = l;
        bus.in_src_port_i = s;
        bus.rd_i          = r;
        model_edge(v, d, l, s, r);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.rd_i       = 1'b0;
        check_all();
    endtask

    task automatic send_frame(input int len, input logic [NUM_PORTS-1:0] s, input bit seq,
                              input int rd_pct, input int gap_pct);
        logic [BYTE_BUS-1:0] d;
        bit                  acc;
        int                  tries;
        for (int i = 0; i < len; i++) begin
            d = seq ? BYTE_BUS'(i) : BYTE_BUS'($urandom);
            while (int'($urandom_range(0, 99)) < gap_pct)
                cyc(1'b0, '0, 1'b0, s, int'($urandom_range(0, 99)) < rd_pct);
            tries = 0;
            do begin
                acc = m_ready();
                cyc(1'b1, d, i == len - 1, s, int'($urandom_range(0, 99)) < rd_pct);
                tries++;
            end while (!acc && tries < 200);
            if (!acc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte_accept: byte %0d of %0d-byte frame not accepted in 200 cycles", i, len);
                return;
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (m_q.size() > 0 && guard < 20) begin
            cyc(1'b0, '0, 1'b0, '0, 1'b1);
            guard++;
        end
    endtask

    initial begin
        logic [NUM_PORTS-1:0] src;
        int                   len;
        bus.in_valid_i    = 1'b0;
        bus.in_data_i     = '0;
        bus.in_last_i     = 1'b0;
        bus.in_src_port_i = '0;
        bus.rd_i          = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        pin("rst_empty", 512'(bus.empty_o), 512'd1);
        pin("rst_ready", 512'(bus.in_ready_o), 512'd1);
        pin("rst_pkt_cnt", 512'(bus.pkt_cnt_o), 512'd0);
        pin("rst_hdr_len", 512'(bus.hdr_len_o), 512'd0);
        pin("rst_out_port", 512'(bus.out_port_o), 512'd0);
        pin("rst_pkt_hdr", 512'(bus.pkt_hdr_o), 512'd0);
        rst = 1'b1;
        @(negedge clk);
        check_all();

        // 20-byte frame, zero fill past the end
        send_frame(20, 4'b0010, 1'b1, 0, 0);
        pin("f20_empty", 512'(bus.empty_o), 512'd0);
        pin("f20_len", 512'(bus.hdr_len_o), 512'd20);
        pin("f20_port", 512'(bus.out_port_o), 512'(4'b1101));
        pin("f20_cnt", 512'(bus.pkt_cnt_o), 512'd1);
        pin("f20_b19", 512'(bus.pkt_hdr_o[19]), 512'(8'h13));
        pin("f20_b20", 512'(bus.pkt_hdr_o[20]), 512'd0);
        pin("f20_b63", 512'(bus.pkt_hdr_o[63]), 512'd0);
        cyc(1'b0, '0, 1'b0, '0, 1'b1);

        // 100-byte frame truncates to the header window
        send_frame(100, 4'b0001, 1'b1, 0, 0);
        pin("f100_len", 512'(bus.hdr_len_o), 512'd64);
        pin("f100_b63", 512'(bus.pkt_hdr_o[63]), 512'(8'h3F));
        pin("f100_port", 512'(bus.out_port_o), 512'(4'b1110));
        cyc(1'b0, '0, 1'b0, '0, 1'b1);

        // Ring full: third frame stalls until a pop
        send_frame(10, 4'b0100, 1'b1, 0, 0);
        send_frame(10, 4'b0100, 1'b1, 0, 0);
        pin("full_ready", 512'(bus.in_ready_o), 512'd0);
        cyc(1'b1, 8'h55, 1'b0, 4'b0100, 1'b0);
        pin("full_ready_held", 512'(bus.in_ready_o), 512'd0);
        cyc(1'b1, 8'h55, 1'b0, 4'b0100, 1'b1);
        pin("pop_ready", 512'(bus.in_ready_o), 512'd1);
        send_frame(10, 4'b1000, 1'b1, 0, 0);
        pin("third_cnt", 512'(bus.pkt_cnt_o), 512'd5);
        drain();
        pin("drained_empty", 512'(bus.empty_o), 512'd1);

        // Commit and pop in the same cycle with one header queued
        send_frame(5, 4'b0001, 1'b1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1'b1, BYTE_BUS'(8'h80 + i), 1'b0, 4'b0010, 1'b0);
        cyc(1'b1, 8'h86, 1'b1, 4'b0010, 1'b1);
        pin("cp_empty", 512'(bus.empty_o), 512'd0);
        pin("cp_len", 512'(bus.hdr_len_o), 512'd7);
        pin("cp_b6", 512'(bus.pkt_hdr_o[6]), 512'(8'h86));
        pin("cp_port", 512'(bus.out_port_o), 512'(4'b1101));
        drain();

        // Reset in the middle of a frame discards it
        for (int i = 0; i < 30; i++) cyc(1'b1, BYTE_BUS'(i), 1'b0, 4'b0100, 1'b0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b1;
        @(negedge clk);
        send_frame(5, 4'b0100, 1'b1, 0, 0);
        pin("rr_len", 512'(bus.hdr_len_o), 512'd5);
        pin("rr_cnt", 512'(bus.pkt_cnt_o), 512'd1);
        drain();

        // Single-byte frame, next frame starts immediately
        cyc(1'b1, 8'hAB, 1'b1, 4'b1000, 1'b0);
        pin("one_len", 512'(bus.hdr_len_o), 512'd1);
        pin("one_b0", 512'(bus.pkt_hdr_o[0]), 512'(8'hAB));
        pin("one_ready", 512'(bus.in_ready_o), 512'd1);
        send_frame(3, 4'b0001, 1'b1, 0, 0);
        drain();

        // Random frames with gaps and random pops
        for (int f = 0; f < 300; f++) begin
            case ($urandom_range(0, 5))
                0:       len = 1;
                1:       len = 63;
                2:       len = 64;
                3:       len = 65;
                default: len = int'($urandom_range(1, 120));
            endcase
            src = NUM_PORTS'(1) << $urandom_range(0, NUM_PORTS - 1);
            send_frame(len, src, 1'b0, 40, 20);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
